// File: rtl/fsmc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fsmc_mem_arbiter
//
// Arbiter for the shared single-port text/pixel RAM. Each RAM cycle goes to
// either the VGA fetch side or the FSMC host side. Video has priority.
// A host RAM op that has been refused MAX_WAIT cycles in a row is forced
// through ahead of video. The arbiter also owns the host auto-increment
// index pointer. It steers the registered RAM read data back to whichever
// requester issued the read one cycle earlier.
//
// Optional build macro: ARB_STATS_EN adds two saturating 16-bit stall/force
// counters as extra outputs. Arbitration is the same with or without it.
//
// Ports:
//   clk_i, reset_i        system clock, synchronous active-high reset
//   host_valid_i          host op present this cycle
//   host_op_i             00 load index, 01 write, 10 read, 11 no-op
//   host_wdata_i          write data; [AW-1:0] is the new index for op 00
//   host_ready_o          op accepted when host_valid_i && host_ready_o
//   host_rvalid_o         host read data valid (one cycle after issue)
//   host_rdata_o          host read data
//   index_o               current host index
//   vid_req_i/vid_addr_i  video fetch request and address
//   vid_grant_o           video request issued to RAM this cycle
//   vid_rvalid_o          video read data valid (one cycle after grant)
//   vid_rdata_o           video read data
//   ram_addr_o            RAM address (combinational from grant)
//   ram_we_o, ram_wdata_o RAM write enable and data
//   ram_rdata_i           RAM read data, 1-cycle registered latency
//   host_stall_cnt_o      [ARB_STATS_EN] refused host RAM-op cycles
//   force_cnt_o           [ARB_STATS_EN] host grants forced past video
// ---------------------------------------------------------------------------
module fsmc_mem_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          host_valid_i,
    input  logic [1:0]    host_op_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_ready_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,
    output logic [AW-1:0] index_o,
    input  logic          vid_req_i,
    input  logic [AW-1:0] vid_addr_i,
    output logic          vid_grant_o,
    output logic          vid_rvalid_o,
    output logic [DW-1:0] vid_rdata_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_we_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   host_stall_cnt_o,
    output logic [15:0]   force_cnt_o
`endif
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } host_op_e;

    // Records who owns the read data that comes back on the next cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_HOST = 2'b01,
        TAG_VID  = 2'b10
    } tag_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [AW-1:0] index_q, index_d;
    logic [3:0]    wait_q,  wait_d;
    tag_e          tag_q,   tag_d;

    logic op_is_ram;
    logic host_ram_op;
    logic host_win;
    logic vid_win;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            index_q <= '0;
            wait_q  <= '0;
            tag_q   <= TAG_NONE;
        end else begin
            index_q <= index_d;
            wait_q  <= wait_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        op_is_ram   = (host_op_i == OP_WRITE) || (host_op_i == OP_READ);
        host_ram_op = host_valid_i && op_is_ram;

        // The host takes the RAM when video is idle. Once the host has been
        // refused MAX_WAIT cycles in a row, it takes the RAM ahead of video.
        host_win = !reset_i && host_ram_op && (!vid_req_i || (wait_q == MAX_WAIT_C));
        vid_win  = !reset_i && vid_req_i && !host_win;

        host_ready_o = !reset_i && (op_is_ram ? host_win : 1'b1);
        vid_grant_o  = vid_win;

        ram_addr_o  = vid_win ? vid_addr_i : index_q;
        ram_we_o    = host_win && (host_op_i == OP_WRITE);
        ram_wdata_o = host_wdata_i;

        index_d = index_q;
        if (host_valid_i && (host_op_i == OP_LOAD)) begin
            index_d = host_wdata_i[AW-1:0];
        end else if (host_win) begin
            index_d = index_q + 1'b1;
        end

        wait_d = '0;
        if (host_ram_op && !host_win) begin
            wait_d = (wait_q == MAX_WAIT_C) ? wait_q : wait_q + 4'd1;
        end

        tag_d = TAG_NONE;
        if (host_win && (host_op_i == OP_READ)) begin
            tag_d = TAG_HOST;
        end else if (vid_win) begin
            tag_d = TAG_VID;
        end

        // Gating with reset drops a response whose return cycle is being reset.
        host_rvalid_o = !reset_i && (tag_q == TAG_HOST);
        vid_rvalid_o  = !reset_i && (tag_q == TAG_VID);
        host_rdata_o  = ram_rdata_i;
        vid_rdata_o   = ram_rdata_i;
        index_o       = index_q;
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] force_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= '0;
            force_q <= '0;
        end else begin
            if (host_ram_op && !host_win && (stall_q != '1)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (host_win && vid_req_i && (force_q != '1)) begin
                force_q <= force_q + 16'd1;
            end
        end
    end

    assign host_stall_cnt_o = stall_q;
    assign force_cnt_o      = force_q;
`endif

endmodule

// File: tb/tb_fsmc_mem_arbiter.sv
module tb_fsmc_mem_arbiter;

    localparam int AW       = 10;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 3;
    localparam int DEPTH    = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_valid;
    logic [1:0]    host_op;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] index;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_grant;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
`ifdef ARB_STATS_EN
    logic [15:0]   host_stall_cnt;
    logic [15:0]   force_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fsmc_mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .host_valid_i(host_valid),
        .host_op_i(host_op),
        .host_wdata_i(host_wdata),
        .host_ready_o(host_ready),
        .host_rvalid_o(host_rvalid),
        .host_rdata_o(host_rdata),
        .index_o(index),
        .vid_req_i(vid_req),
        .vid_addr_i(vid_addr),
        .vid_grant_o(vid_grant),
        .vid_rvalid_o(vid_rvalid),
        .vid_rdata_o(vid_rdata),
        .ram_addr_o(ram_addr),
        .ram_we_o(ram_we),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
`ifdef ARB_STATS_EN
        ,
        .host_stall_cnt_o(host_stall_cnt),
        .force_cnt_o(force_cnt)
`endif
    );

    // Physical single-port RAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the index pointer as an integer, a count of consecutive
    // refusals, a shadow copy of RAM contents, and a queue of pending
    // responses. Each entry names its owner and holds the data it must carry.
    typedef struct {
        int            who;   // 1 = host, 2 = video
        logic [DW-1:0] data;
    } ret_t;

    ret_t          ret_q[$];
    logic [DW-1:0] shadow [DEPTH];
    int            m_index   = 0;
    int            m_refused = 0;
    int            m_stall   = 0;
    int            m_force   = 0;
    bit            m_known   = 1'b0;

    always @(negedge clk) begin
        bit            ramop;
        bit            hwin;
        bit            vg;
        bit            is_write;
        ret_t          r;
        int            who;
        logic [DW-1:0] rdat;

        who  = 0;
        rdat = '0;
        if (ret_q.size() > 0) begin
            r    = ret_q.pop_front();
            who  = r.who;
            rdat = r.data;
        end
        if (reset) who = 0;

        ramop    = host_valid && (host_op == 2'b01 || host_op == 2'b10);
        hwin     = !reset && ramop && (!vid_req || m_refused >= MAX_WAIT);
        vg       = !reset && vid_req && !hwin;
        is_write = hwin && (host_op == 2'b01);

        if (m_known) begin
            chk("vid_grant", {31'd0, vid_grant}, {31'd0, vg});
            chk("ram_we", {31'd0, ram_we}, {31'd0, is_write});
            if (host_valid)
                chk("host_ready", {31'd0, host_ready}, {31'd0, !reset && (ramop ? hwin : 1'b1)});
            if (!reset)
                chk("ram_addr", {22'd0, ram_addr}, vg ? {22'd0, vid_addr} : m_index);
            if (is_write)
                chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, host_wdata});
            chk("host_rvalid", {31'd0, host_rvalid}, (who == 1) ? 32'd1 : 32'd0);
            chk("vid_rvalid", {31'd0, vid_rvalid}, (who == 2) ? 32'd1 : 32'd0);
            if (who == 1) chk("host_rdata", {16'd0, host_rdata}, {16'd0, rdat});
            if (who == 2) chk("vid_rdata", {16'd0, vid_rdata}, {16'd0, rdat});
            chk("rvalid_exclusive", {31'd0, host_rvalid && vid_rvalid}, 32'd0);
            chk("index", {22'd0, index}, m_index);
`ifdef ARB_STATS_EN
            chk("host_stall_cnt", {16'd0, host_stall_cnt}, m_stall);
            chk("force_cnt", {16'd0, force_cnt}, m_force);
`endif
        end

        if (reset) begin
            m_index   = 0;
            m_refused = 0;
            m_stall   = 0;
            m_force   = 0;
            m_known   = 1'b1;
            ret_q.delete();
        end else begin
            if (host_valid && host_op == 2'b00) begin
                m_index = int'(host_wdata[AW-1:0]);
            end else if (hwin) begin
                if (is_write) shadow[m_index] = host_wdata;
                else          ret_q.push_back('{1, shadow[m_index]});
                m_index = (m_index + 1) % DEPTH;
            end
            if (vg) ret_q.push_back('{2, shadow[vid_addr]});
            if (ramop && !hwin) begin
                m_refused++;
                if (m_stall < 65535) m_stall++;
            end else begin
                m_refused = 0;
            end
            if (hwin && vid_req && m_force < 65535) m_force++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 16'($urandom);
            shadow[i] = mem[i];
        end
        reset      = 1'b1;
        host_valid = 1'b0;
        host_op    = 2'b11;
        host_wdata = '0;
        vid_req    = 1'b0;
        vid_addr   = '0;
        step();
        step();

        // Load near the top, write two words across the wrap, reload, read back.
        reset      = 1'b0;
        host_valid = 1'b1;
        host_op    = 2'b00;
        host_wdata = 16'h03FE;
        look(); chk("s1_load_ready", {31'd0, host_ready}, 32'd1); step();
        host_op    = 2'b01;
        host_wdata = 16'hAAAA;
        look(); chk("s1_wr0_we", {31'd0, ram_we}, 32'd1);
        chk("s1_wr0_addr", {22'd0, ram_addr}, 32'h3FE); step();
        host_wdata = 16'hBBBB;
        look(); chk("s1_wr1_addr", {22'd0, ram_addr}, 32'h3FF); step();
        host_op    = 2'b00;
        host_wdata = 16'h03FE;
        look(); chk("s1_index_wrapped", {22'd0, index}, 32'h000); step();
        host_op    = 2'b10;
        look(); chk("s1_rd0_ready", {31'd0, host_ready}, 32'd1); step();
        look(); chk("s1_rd0_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk("s1_rd0_data", {16'd0, host_rdata}, 32'hAAAA); step();
        host_valid = 1'b0;
        look(); chk("s1_rd1_data", {16'd0, host_rdata}, 32'hBBBB);
        chk("s1_index_end", {22'd0, index}, 32'h000); step();

        // Video held high: a host write is refused MAX_WAIT cycles, then forced.
        vid_req  = 1'b1;
        vid_addr = 10'h100;
        for (int rep = 0; rep < 2; rep++) begin
            host_valid = 1'b1;
            host_op    = 2'b01;
            host_wdata = 16'h1111;
            for (int k = 0; k < MAX_WAIT; k++) begin
                look();
                chk("s2_refused_ready", {31'd0, host_ready}, 32'd0);
                chk("s2_refused_vgrant", {31'd0, vid_grant}, 32'd1);
                step();
            end
            look();
            chk("s2_forced_ready", {31'd0, host_ready}, 32'd1);
            chk("s2_forced_vgrant", {31'd0, vid_grant}, 32'd0);
            chk("s2_forced_we", {31'd0, ram_we}, 32'd1);
            step();
            host_valid = 1'b0;
            look(); chk("s2_video_back", {31'd0, vid_grant}, 32'd1); step();
        end
`ifdef ARB_STATS_EN
        look();
        chk("s6_stall_cnt", {16'd0, host_stall_cnt}, 32'd6);
        chk("s6_force_cnt", {16'd0, force_cnt}, 32'd2);
`endif
        host_valid = 1'b1;
        look(); chk("s2_wait_cleared", {31'd0, host_ready}, 32'd0); step();
        host_valid = 1'b0;
        look(); step();

        // Host read and video in the same cycle: video goes first.
        vid_addr   = 10'h3FE;
        host_valid = 1'b1;
        host_op    = 2'b10;
        look(); chk("s3_vgrant", {31'd0, vid_grant}, 32'd1);
        chk("s3_host_wait", {31'd0, host_ready}, 32'd0); step();
        vid_req = 1'b0;
        look(); chk("s3_vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
        chk("s3_vid_rdata", {16'd0, vid_rdata}, 32'hAAAA);
        chk("s3_no_host_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("s3_host_ready", {31'd0, host_ready}, 32'd1); step();
        host_valid = 1'b0;
        look(); chk("s3_host_rvalid", {31'd0, host_rvalid}, 32'd1); step();

        // Alternating video pulses against back-to-back host reads.
        host_valid = 1'b1;
        host_op    = 2'b10;
        for (int k = 0; k < 12; k++) begin
            vid_req  = k[0];
            vid_addr = 10'(k * 37);
            step();
        end
        host_valid = 1'b0;
        vid_req    = 1'b0;
        step();

        // Reset in the cycle after a host read issues.
        host_valid = 1'b1;
        host_op    = 2'b10;
        look(); chk("s5_read_ready", {31'd0, host_ready}, 32'd1); step();
        reset      = 1'b1;
        host_valid = 1'b0;
        look(); chk("s5_rvalid_suppressed", {31'd0, host_rvalid}, 32'd0); step();
        reset = 1'b0;
        look(); chk("s5_index_zero", {22'd0, index}, 32'd0);
        chk("s5_rvalid_after", {31'd0, host_rvalid}, 32'd0); step();

        // Randomized traffic with periodic solid video bursts to hit forcing.
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            host_valid = ($urandom_range(0, 3) != 0);
            host_op    = 2'($urandom_range(0, 3));
            host_wdata = 16'($urandom);
            vid_req    = ((i % 200) < 25) ? 1'b1 : ($urandom_range(0, 2) != 0);
            vid_addr   = 10'($urandom);
            step();
        end
        reset      = 1'b0;
        host_valid = 1'b0;
        vid_req    = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsmc_mem_arbiter.md
Name: fsmc_mem_arbiter

Overview:
Controls the shared single-port 1024x16 text/pixel RAM. That RAM is written and read by the FSMC host side and scanned by the VGA fetch side.
- Owns the host auto-increment index pointer.
- Arbitrates every RAM cycle between video fetch (priority) and host read/write, with a starvation guard.
- Returns read data to the correct requester one cycle after issue.
- Sits between the FSMC strobe decoder, the RAM and the vga block.

Parameters:
AW, 10, RAM address width; index and addresses are AW bits.
DW, 16, RAM data width.
MAX_WAIT, 3, consecutive cycles a host RAM op may be refused before it is forced through ahead of video (1..15).

Ports:
clk  in  1  single system clock (PLL c0 domain)
reset  in  1  synchronous, active-high
host_valid  in  1  host op present this cycle
host_op  in  2  00 load index, 01 write at index, 10 read at index, 11 no-op
host_wdata  in  DW  write data; bits [AW-1:0] are the new index for op 00
host_ready  out  1  op accepted when host_valid && host_ready
host_rvalid  out  1  host read data valid
host_rdata  out  DW  host read data
index  out  AW  current host index (drives leds)
vid_req  in  1  video fetch request
vid_addr  in  AW  video fetch address
vid_grant  out  1  video request issued to RAM this cycle
vid_rvalid  out  1  video read data valid
vid_rdata  out  DW  video read data
ram_addr  out  AW  RAM address (combinational from grant)
ram_we  out  1  RAM write enable
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data; registered, 1-cycle latency

Behaviour:
- Reset (synchronous, takes effect at the clock edge with reset=1): index=0, wait_cnt=0, host_rvalid=0, vid_rvalid=0, last-grant tag=none. While reset=1: ram_we=0, vid_grant=0, host_ready=0.
- Op 00 and op 11 never use the RAM. host_ready=1 for them in every non-reset cycle. Op 00 sets index <= host_wdata[AW-1:0] at the next edge.
- RAM op (01/10) grant rule, evaluated each cycle:
  - host_win = host_valid && op is a RAM op && (!vid_req || wait_cnt==MAX_WAIT).
  - Otherwise vid_grant = vid_req.
  - host_ready = host_win for RAM ops.
- Granted host op:
  - ram_addr = index.
  - Write: ram_we=1, ram_wdata=host_wdata.
  - Index then increments, wrapping 2^AW-1 -> 0.
- Granted video: ram_addr=vid_addr, ram_we=0. When nothing is granted: ram_addr=index, ram_we=0.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle a host RAM op is presented but refused.
  - Clears on acceptance, or when host_valid=0 or op is not 01/10.
- Refused video: vid_grant=0. The requester holds vid_req/vid_addr; there is no internal video queue.
- Read return: the tag registered at the issue edge steers ram_rdata the next cycle.
  - host_rvalid=1 for one cycle with host_rdata=ram_rdata one cycle after a host read is accepted.
  - vid_rvalid is likewise asserted one cycle after vid_grant.
  - Never both asserted in the same cycle.
- A write returns no rvalid. Back-to-back accepted ops give one op per cycle, full throughput.
- Reset asserted the cycle after an issued read: the rvalid for that read is suppressed (rvalid=0).
- Host write and video read requested together with wait_cnt<MAX_WAIT: video wins, the write waits, and RAM contents are unchanged that cycle.

Optional Feature:
ARB_STATS_EN: adds output host_stall_cnt (16 bits) and output force_cnt (16 bits). Both are saturating counters, cleared by reset.
- host_stall_cnt counts refused host RAM-op cycles.
- force_cnt counts grants where host_win occurred with vid_req=1.
- Without the macro the ports and logic are absent; arbitration is identical either way.

Test Plan:
- Reset, then op00 wdata=0x03FE, write 0xAAAA, write 0xBBBB, op00 0x03FE, read, read -> RAM[0x3FE]=0xAAAA, RAM[0x3FF]=0xBBBB, host_rdata 0xAAAA then 0xBBBB one cycle after each accept; index ends at 0x000 (wrap).
- vid_req held high continuously, host write pending, MAX_WAIT=3 -> host_ready low 3 cycles, high on 4th; vid_grant=0 that cycle, 1 again next cycle; wait_cnt back to 0.
- Host read and vid_req same cycle, wait_cnt=0 -> vid_grant=1, vid_rvalid next cycle with RAM[vid_addr]; host_rvalid stays 0 until host later granted.
- Alternating vid_req pulses with back-to-back host reads -> each response routed to the correct requester; host_rvalid and vid_rvalid never high together.
- Reset asserted the cycle after a host read is accepted -> host_rvalid=0, index=0, wait_cnt=0 after the edge.
- With ARB_STATS_EN, scenario 2 repeated twice -> host_stall_cnt=6, force_cnt=2.
